uart_tx_fifo: RTL and testbench

Parametrised serial transmitter for the 6809 system bus: the next generation of the fixed 8N1 transmitter.
- Host writes words into an internal FIFO.
- A frame engine shifts each word out LSB-first, with configurable data width, parity and stop bits.
- Frames stream back-to-back with no idle gap while the FIFO holds data.
- Sits between the host data bus and the external TX pin; clocked by the bit-tick-rate clock (TICKS_PER_BIT clk cycles per serial bit).

---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered serial transmitter: host words queue in a small FIFO and stream out LSB-first.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN (adds send_break).
module uart_tx_fifo #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          host_wr,
`ifdef UART_TX_BREAK_EN
  input  logic                          send_break,
`endif
  output logic                          host_dir,
  output logic                          serout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK, BRK_REL} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                 push, pop, tick_end, brk;

`ifdef UART_TX_BREAK_EN
  assign brk = send_break;
`else
  assign brk = 1'b0;
`endif

  assign host_dir   = (count_q != FULL);
  assign push       = host_wr && host_dir;
  assign tick_end   = (tick_q == TICK_LAST);
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    overflow_d = overflow_q || (host_wr && !host_dir);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame engine; pops happen from IDLE or straight out of the last stop bit so frames abut.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_end ? '0 : tick_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    serout  = 1'b1;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (brk) begin
          serout  = 1'b0;
          state_d = BREAK;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          par_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        serout = 1'b0;
        if (tick_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        serout = shift_q[0];
        if (tick_end) begin
          shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ shift_q[0];
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        serout = (PARITY == 2) ? ~par_q : par_q;
        if (tick_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (tick_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (count_q != '0 && !brk) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              par_d   = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      BREAK: begin
        serout = 1'b0;
        tick_d = '0;
        if (!brk) state_d = BRK_REL;
      end
      BRK_REL: begin
        if (tick_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '1;
      par_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances (8N1, 7E2, 7O2) checked sample-by-sample
// against frames built from each written word; break tests need `define UART_TX_BREAK_EN.
module tb_uart_tx_fifo;

  localparam int TICKS   = 16;
  localparam int FRAME_A = (1 + 8 + 0 + 1) * TICKS;
  localparam int FRAME_P = (1 + 7 + 1 + 2) * TICKS;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic [7:0]  word;
  } frame_t;

  logic       clk, reset;
  logic [7:0] din_a;
  logic       wr_a, dir_a, ser_a, busy_a, ovf_a;
  logic [2:0] cnt_a;
  logic [6:0] din_p;
  logic       wr_p, dir_b, ser_b, busy_b, ovf_b, dir_c, ser_c, busy_c, ovf_c;
  logic [2:0] cnt_b, cnt_c;
`ifdef UART_TX_BREAK_EN
  logic       send_break;
`endif

  int     compared, mismatched;
  frame_t sb_q [3][$];
  bit     mon_en [3];
  bit     mon_active [3];

  uart_tx_fifo dut_a (
    .clk(clk), .reset(reset), .din(din_a), .host_wr(wr_a),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .host_dir(dir_a), .serout(ser_a), .busy(busy_a), .fifo_count(cnt_a), .overflow(ovf_a)
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .din(din_p), .host_wr(wr_p),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .host_dir(dir_b), .serout(ser_b), .busy(busy_b), .fifo_count(cnt_b), .overflow(ovf_b)
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset(reset), .din(din_p), .host_wr(wr_p),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .host_dir(dir_c), .serout(ser_c), .busy(busy_c), .fifo_count(cnt_c), .overflow(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic frame_t make_frame(input logic [7:0] w, input int db, input int par, input int sb);
    frame_t f;
    logic   p;
    f.bits  = '0;
    f.word  = w;
    f.nbits = 1;
    p       = 1'b0;
    for (int i = 0; i < db; i++) begin
      f.bits[f.nbits] = w[i];
      p = p ^ w[i];
      f.nbits = f.nbits + 1;
    end
    if (par != 0) begin
      f.bits[f.nbits] = (par == 2) ? ~p : p;
      f.nbits = f.nbits + 1;
    end
    for (int i = 0; i < sb; i++) begin
      f.bits[f.nbits] = 1'b1;
      f.nbits = f.nbits + 1;
    end
    return f;
  endfunction

  function automatic logic ser_of(input int i);
    case (i)
      0:       return ser_a;
      1:       return ser_b;
      default: return ser_c;
    endcase
  endfunction

  // Each sample of a frame is compared against the bit the popped scoreboard entry predicts.
  task automatic run_monitor(input int inst);
    frame_t f;
    int     bad;
    bit     aborted;
    forever begin
      @(posedge clk);
      if (mon_en[inst] && ser_of(inst) === 1'b0) begin
        if (sb_q[inst].size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_start inst=%0d got=start_bit expected=idle_high", inst);
          for (int w = 0; w < 2000 && ser_of(inst) === 1'b0; w++) @(posedge clk);
        end else begin
          f = sb_q[inst].pop_front();
          mon_active[inst] = 1'b1;
          bad = 0;
          aborted = 1'b0;
          for (int s = 0; s < f.nbits * TICKS; s++) begin
            if (s != 0) @(posedge clk);
            if (!mon_en[inst]) begin
              aborted = 1'b1;
              break;
            end
            if (ser_of(inst) !== f.bits[s / TICKS]) bad++;
          end
          mon_active[inst] = 1'b0;
          if (!aborted) begin
            compared++;
            if (bad != 0) begin
              mismatched++;
              $display("[TB] FAIL frame inst=%0d word=%02h bad_samples got=%0d expected=0", inst, f.word, bad);
            end
          end
        end
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);
  initial run_monitor(2);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) mon_en[i] = 1'b0;
    wr_a  = 1'b0;
    wr_p  = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_q[i].delete();
      mon_en[i] = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0 || mon_active[0] || mon_active[1] ||
            mon_active[2] || sb_q[0].size() != 0 || sb_q[1].size() != 0 || sb_q[2].size() != 0) && n < 3000) begin
      step();
      n++;
    end
    compared++;
    if (n >= 3000) begin
      mismatched++;
      $display("[TB] FAIL %s_drain got=still_busy_after %0d cycles expected=idle", name, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    compared++; if (ser_a !== 1'b1)    begin mismatched++; $display("[TB] FAIL reset_serout got=%b expected=1", ser_a); end
    compared++; if (dir_a !== 1'b1)    begin mismatched++; $display("[TB] FAIL reset_host_dir got=%b expected=1", dir_a); end
    compared++; if (busy_a !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset_busy got=%b expected=0", busy_a); end
    compared++; if (cnt_a !== 3'd0)    begin mismatched++; $display("[TB] FAIL reset_count got=%0d expected=0", cnt_a); end
    compared++; if (ovf_a !== 1'b0)    begin mismatched++; $display("[TB] FAIL reset_overflow got=%b expected=0", ovf_a); end
    compared++; if ({ser_b, ser_c} !== 2'b11) begin mismatched++; $display("[TB] FAIL reset_serout_parity got=%b expected=11", {ser_b, ser_c}); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) mon_en[i] = 1'b1;
  endtask

  task automatic test_single_frame();
    int n;
    do_reset();
    din_a = 8'hA5;
    wr_a  = 1'b1;
    sb_q[0].push_back(make_frame(8'hA5, 8, 0, 1));
    step();
    wr_a = 1'b0;
    compared++; if (cnt_a !== 3'd1) begin mismatched++; $display("[TB] FAIL latency_count_after_write got=%0d expected=1", cnt_a); end
    compared++; if (ser_a !== 1'b1) begin mismatched++; $display("[TB] FAIL latency_serout_after_write got=%b expected=1", ser_a); end
    compared++; if (busy_a !== 1'b1) begin mismatched++; $display("[TB] FAIL latency_busy_after_write got=%b expected=1", busy_a); end
    step();
    compared++; if (cnt_a !== 3'd0) begin mismatched++; $display("[TB] FAIL latency_count_after_pop got=%0d expected=0", cnt_a); end
    compared++; if (ser_a !== 1'b0) begin mismatched++; $display("[TB] FAIL latency_start_bit got=%b expected=0", ser_a); end
    n = 0;
    while (busy_a === 1'b1 && n < 400) begin
      step();
      n++;
    end
    compared++; if (n != FRAME_A) begin mismatched++; $display("[TB] FAIL frame_length_8n1 got=%0d expected=%0d", n, FRAME_A); end
    wait_idle("single");
  endtask

  task automatic test_back_to_back();
    int     n;
    int     exp_cnt [4] = '{1, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din_a = 8'(i + 1);
      wr_a  = 1'b1;
      sb_q[0].push_back(make_frame(8'(i + 1), 8, 0, 1));
      step();
      compared++;
      if (cnt_a !== 3'(exp_cnt[i])) begin mismatched++; $display("[TB] FAIL b2b_count_write%0d got=%0d expected=%0d", i, cnt_a, exp_cnt[i]); end
    end
    din_a = 8'h05;
    sb_q[0].push_back(make_frame(8'h05, 8, 0, 1));
    step();
    compared++; if (cnt_a !== 3'd4) begin mismatched++; $display("[TB] FAIL b2b_count_full got=%0d expected=4", cnt_a); end
    compared++; if (dir_a !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_host_dir_full got=%b expected=0", dir_a); end
    for (int i = 0; i < 6; i++) begin
      din_a = 8'hF0 + 8'(i);
      step();
    end
    wr_a = 1'b0;
    compared++; if (ovf_a !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_overflow got=%b expected=1", ovf_a); end
    compared++; if (cnt_a !== 3'd4) begin mismatched++; $display("[TB] FAIL b2b_count_after_drop got=%0d expected=4", cnt_a); end
    // First start bit is one edge after the first write; 10 edges have elapsed since that write.
    n = 0;
    while (busy_a === 1'b1 && n < 2000) begin
      step();
      n++;
    end
    compared++; if (n != 5 * FRAME_A - 9) begin mismatched++; $display("[TB] FAIL b2b_stream_length got=%0d expected=%0d", n, 5 * FRAME_A - 9); end
    wait_idle("b2b");
    compared++; if (ovf_a !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_overflow_sticky got=%b expected=1", ovf_a); end
  endtask

  task automatic test_push_pop_same_cycle();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din_a = 8'hA1 + 8'(i);
      wr_a  = 1'b1;
      sb_q[0].push_back(make_frame(8'hA1 + 8'(i), 8, 0, 1));
      step();
    end
    wr_a = 1'b0;
    repeat (FRAME_A - 3) step();
    compared++; if (cnt_a !== 3'd3) begin mismatched++; $display("[TB] FAIL pushpop_count_before got=%0d expected=3", cnt_a); end
    din_a = 8'hB5;
    wr_a  = 1'b1;
    sb_q[0].push_back(make_frame(8'hB5, 8, 0, 1));
    step();
    compared++; if (cnt_a !== 3'd3) begin mismatched++; $display("[TB] FAIL pushpop_count_same got=%0d expected=3", cnt_a); end
    compared++; if (ser_a !== 1'b0) begin mismatched++; $display("[TB] FAIL pushpop_no_gap_start got=%b expected=0", ser_a); end
    din_a = 8'hC6;
    sb_q[0].push_back(make_frame(8'hC6, 8, 0, 1));
    step();
    wr_a = 1'b0;
    compared++; if (cnt_a !== 3'd4) begin mismatched++; $display("[TB] FAIL pushpop_count_full got=%0d expected=4", cnt_a); end
    compared++; if (dir_a !== 1'b0) begin mismatched++; $display("[TB] FAIL pushpop_host_dir got=%b expected=0", dir_a); end
    wait_idle("pushpop");
    compared++; if (ovf_a !== 1'b0) begin mismatched++; $display("[TB] FAIL pushpop_overflow got=%b expected=0", ovf_a); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din_a = (i == 0) ? 8'h55 : 8'h11 * 8'(i);
      wr_a  = 1'b1;
      sb_q[0].push_back(make_frame(din_a, 8, 0, 1));
      step();
    end
    wr_a = 1'b0;
    repeat (40) step();
    mon_en[0] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_q[0].delete();
    compared++; if (ser_a !== 1'b1)  begin mismatched++; $display("[TB] FAIL midreset_serout got=%b expected=1", ser_a); end
    compared++; if (cnt_a !== 3'd0)  begin mismatched++; $display("[TB] FAIL midreset_count got=%0d expected=0", cnt_a); end
    compared++; if (ovf_a !== 1'b0)  begin mismatched++; $display("[TB] FAIL midreset_overflow got=%b expected=0", ovf_a); end
    compared++; if (busy_a !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy got=%b expected=0", busy_a); end
    bad = 0;
    repeat (300) begin
      step();
      if (ser_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("[TB] FAIL midreset_no_more_frames got=%0d active_samples expected=0", bad); end
    mon_en[0] = 1'b1;
  endtask

  task automatic test_parity();
    int n;
    do_reset();
    din_p = 7'h07;
    wr_p  = 1'b1;
    sb_q[1].push_back(make_frame(8'h07, 7, 1, 2));
    sb_q[2].push_back(make_frame(8'h07, 7, 2, 2));
    step();
    wr_p = 1'b0;
    step();
    n = 0;
    while (busy_b === 1'b1 && n < 500) begin
      step();
      n++;
      if (n == 8 * TICKS + 7) begin
        compared++; if (ser_b !== 1'b1) begin mismatched++; $display("[TB] FAIL parity_even_bit got=%b expected=1", ser_b); end
        compared++; if (ser_c !== 1'b0) begin mismatched++; $display("[TB] FAIL parity_odd_bit got=%b expected=0", ser_c); end
      end
    end
    compared++; if (n != FRAME_P) begin mismatched++; $display("[TB] FAIL frame_length_7e2 got=%0d expected=%0d", n, FRAME_P); end
    compared++; if (busy_c !== 1'b0) begin mismatched++; $display("[TB] FAIL frame_end_7o2_busy got=%b expected=0", busy_c); end
    wait_idle("parity");
  endtask

  task automatic test_random_stream();
    logic [7:0] w;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      w     = 8'($urandom_range(0, 255));
      din_a = w;
      wr_a  = 1'b1;
      sb_q[0].push_back(make_frame(w, 8, 0, 1));
      step();
      wr_a = 1'b0;
      repeat ($urandom_range(130, 250)) step();
    end
    wait_idle("random");
    compared++; if (ovf_a !== 1'b0) begin mismatched++; $display("[TB] FAIL random_overflow got=%b expected=0", ovf_a); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int n, bad, highs;
    do_reset();
    send_break = 1'b0;
    din_a = 8'h3C;
    wr_a  = 1'b1;
    sb_q[0].push_back(make_frame(8'h3C, 8, 0, 1));
    step();
    wr_a = 1'b0;
    repeat (40) step();
    send_break = 1'b1;
    n = 0;
    while ((sb_q[0].size() != 0 || mon_active[0]) && n < 400) begin
      step();
      n++;
    end
    mon_en[0] = 1'b0;
    compared++; if (n >= 400) begin mismatched++; $display("[TB] FAIL break_frame_done got=timeout expected=frame_end"); end
    bad = 0;
    repeat (20) begin
      step();
      if (ser_a !== 1'b0) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("[TB] FAIL break_line_low got=%0d high_samples expected=0", bad); end
    din_a = 8'h81;
    wr_a  = 1'b1;
    sb_q[0].push_back(make_frame(8'h81, 8, 0, 1));
    step();
    wr_a = 1'b0;
    bad = 0;
    repeat (10) begin
      step();
      if (ser_a !== 1'b0 || cnt_a !== 3'd1) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("[TB] FAIL break_pop_suppressed got=%0d bad_samples expected=0", bad); end
    send_break = 1'b0;
    step();
    mon_en[0] = 1'b1;
    highs = 0;
    while (ser_a === 1'b1 && highs < 100) begin
      highs++;
      step();
    end
    compared++;
    if (highs < TICKS || highs >= 100) begin mismatched++; $display("[TB] FAIL break_release_gap got=%0d expected=at_least_%0d", highs, TICKS); end
    wait_idle("break");
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    wr_a  = 1'b0;
    wr_p  = 1'b0;
    din_a = '0;
    din_p = '0;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      mon_en[i]     = 1'b0;
      mon_active[i] = 1'b0;
    end
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_push_pop_same_cycle();
    test_reset_mid_frame();
    test_parity();
    test_random_stream();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    compared++;
    if (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_leftover got=%0d expected=0", sb_q[0].size() + sb_q[1].size() + sb_q[2].size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
